// File: rtl/audio_rx_pkg.sv
// Shared types for the I2S ADC capture path: receiver state encoding and default word width.
package audio_rx_pkg;

  localparam int DATA_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    WAIT_FRAME,
    SKIP_L,
    SHIFT_L,
    HOLD_L,
    SKIP_R,
    SHIFT_R,
    HOLD_R,
    COMMIT
  } rx_state_t;

  // States in which a word-select edge means the codec cut a word short.
  function automatic logic is_capture_state(input rx_state_t s);
    return (s == SKIP_L) || (s == SHIFT_L) || (s == SKIP_R) || (s == SHIFT_R);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// One-bit synchronizer followed by an edge-detect register; strobes are one Clk wide
// and o_level is the synchronized input at the same pipeline depth as the strobes.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2s_adc_receiver.sv
// WM8731 ADC-side I2S receiver: oversampled in the Clk domain, deserializes stereo frames
// and presents each completed frame through a one-deep valid/ready buffer.
module i2s_adc_receiver
  import audio_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  input  logic                  enable,
  input  logic                  sample_ready,
  input  logic                  clear_overrun,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sample_valid,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic w_bclk_level, w_bclk_rise, w_bclk_fall;
  logic w_lrck_level, w_lrck_rise, w_lrck_fall;
  logic w_dat, w_dat_rise, w_dat_fall;
  logic w_unused;
  logic w_abort;

  rx_state_t             r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shl;
  logic [DATA_WIDTH-1:0] r_shr;
  logic [DATA_WIDTH-1:0] r_left;
  logic [DATA_WIDTH-1:0] r_right;
  logic                  r_valid;
  logic                  r_ovr;
  logic                  r_ferr;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_d     (AUD_BCLK),
    .o_level (w_bclk_level),
    .o_rise  (w_bclk_rise),
    .o_fall  (w_bclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_d     (AUD_ADCLRCK),
    .o_level (w_lrck_level),
    .o_rise  (w_lrck_rise),
    .o_fall  (w_lrck_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dat (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_d     (AUD_ADCDAT),
    .o_level (w_dat),
    .o_rise  (w_dat_rise),
    .o_fall  (w_dat_fall)
  );

  assign w_unused = ^{w_bclk_level, w_bclk_fall, w_lrck_level, w_dat_rise, w_dat_fall};

  // A word-select edge before the word is complete discards the whole frame.
  assign w_abort = is_capture_state(r_state) && (w_lrck_fall || w_lrck_rise);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= WAIT_FRAME;
      r_cnt   <= '0;
      r_shl   <= '0;
      r_shr   <= '0;
      r_left  <= '0;
      r_right <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (r_valid && sample_ready) r_valid <= 1'b0;
      if (clear_overrun)           r_ovr   <= 1'b0;

      if (w_abort) begin
        r_ferr  <= 1'b1;
        r_cnt   <= '0;
        r_state <= w_lrck_fall ? SKIP_L : WAIT_FRAME;
      end else begin
        case (r_state)
          WAIT_FRAME: begin
            if (w_lrck_fall && enable) begin
              r_cnt   <= '0;
              r_state <= SKIP_L;
            end
          end
          SKIP_L: begin
            if (w_bclk_rise) r_state <= SHIFT_L;
          end
          SHIFT_L: begin
            if (w_bclk_rise) begin
              r_shl <= {r_shl[DATA_WIDTH-2:0], w_dat};
              if (r_cnt == LAST_BIT) begin
                r_cnt   <= '0;
                r_state <= HOLD_L;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          HOLD_L: begin
            if (w_lrck_rise) r_state <= SKIP_R;
          end
          SKIP_R: begin
            if (w_bclk_rise) r_state <= SHIFT_R;
          end
          SHIFT_R: begin
            if (w_bclk_rise) begin
              r_shr <= {r_shr[DATA_WIDTH-2:0], w_dat};
              if (r_cnt == LAST_BIT) begin
                r_cnt   <= '0;
                r_state <= HOLD_R;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          HOLD_R: begin
            if (w_lrck_fall) r_state <= COMMIT;
          end
          COMMIT: begin
            // The lrck_fall that ended this frame also opened the next left word.
            if (!r_valid || sample_ready) begin
              r_left  <= r_shl;
              r_right <= r_shr;
              r_valid <= 1'b1;
            end else begin
              r_ovr <= 1'b1;
            end
            r_cnt   <= '0;
            r_state <= enable ? SKIP_L : WAIT_FRAME;
          end
          default: r_state <= WAIT_FRAME;
        endcase
      end
    end
  end

  assign sample_left  = r_left;
  assign sample_right = r_right;
  assign sample_valid = r_valid;
  assign overrun      = r_ovr;
  assign frame_err    = r_ferr;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: a codec model drives 64-BCLK I2S frames at Clk/16
// and a scoreboard queue holds the frames expected at the valid/ready output.
module tb_i2s_adc_receiver;

  localparam int DW = 16;
  localparam int SS = 2;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          AUD_BCLK = 1'b0;
  logic          AUD_ADCLRCK = 1'b1;
  logic          AUD_ADCDAT = 1'b0;
  logic          enable = 1'b0;
  logic          sample_ready = 1'b0;
  logic          clear_overrun = 1'b0;
  logic [DW-1:0] sample_left;
  logic [DW-1:0] sample_right;
  logic          sample_valid;
  logic          overrun;
  logic          frame_err;

  int          tests  = 0;
  int          fails  = 0;
  int          fe_cnt = 0;
  int          rx_cnt = 0;
  logic        prev_fe = 1'b0;
  logic [31:0] exp_q[$];

  always #10 Clk = ~Clk;

  i2s_adc_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .AUD_BCLK      (AUD_BCLK),
    .AUD_ADCLRCK   (AUD_ADCLRCK),
    .AUD_ADCDAT    (AUD_ADCDAT),
    .enable        (enable),
    .sample_ready  (sample_ready),
    .clear_overrun (clear_overrun),
    .sample_left   (sample_left),
    .sample_right  (sample_right),
    .sample_valid  (sample_valid),
    .overrun       (overrun),
    .frame_err     (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One BCLK period: lines change with the falling edge, codec-style.
  task automatic bclk_cycle(input logic lr, input logic d);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    repeat (8) @(posedge Clk);
    #1;
    AUD_BCLK = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
  endtask

  // Slot 0 carries the previous word's LSB (driven 1 so a missed skip corrupts data).
  task automatic half(input logic lr, input logic [23:0] w, input int nbits, input int ncyc);
    for (int j = 0; j < ncyc; j++) begin
      logic d;
      if (j == 0)          d = 1'b1;
      else if (j <= nbits) d = w[nbits-j];
      else                 d = 1'b0;
      bclk_cycle(lr, d);
    end
  endtask

  task automatic frame(input logic [23:0] l, input logic [23:0] r, input int nbits);
    half(1'b0, l, nbits, 32);
    half(1'b1, r, nbits, 32);
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    exp_q.push_back({l, r});
  endtask

  // Ends the stream: the left-going edge commits the pending frame with enable low,
  // then the receiver idles with ADCLRCK high, ready for the next frame.
  task automatic flush(input int mode, input logic [15:0] el, input logic [15:0] er);
    enable      = 1'b0;
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = 1'b0;
    AUD_ADCDAT  = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    if (mode == 1) check("latency_before", {31'b0, sample_valid}, 32'd0);
    if (mode == 2) sample_ready = 1'b1;
    @(posedge Clk);
    #1;
    if (mode == 1) check("latency_valid", {31'b0, sample_valid}, 32'd1);
    if (mode == 2) begin
      sample_ready = 1'b0;
      check("commit_ready_valid", {31'b0, sample_valid}, 32'd1);
      check("commit_ready_data", {sample_left, sample_right}, {el, er});
      check("commit_ready_overrun", {31'b0, overrun}, 32'd0);
    end
    repeat (3) @(posedge Clk);
    #1;
    AUD_BCLK = 1'b1;
    repeat (8) @(posedge Clk);
    #1;
    half(1'b0, 24'h0, 0, 3);
    half(1'b1, 24'h0, 0, 4);
    enable = 1'b1;
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        prev_fe = 1'b0;
      end else begin
        if (frame_err) begin
          fe_cnt++;
          check("frame_err_width", {31'b0, prev_fe}, 32'd0);
        end
        prev_fe = frame_err;
        if (sample_valid && sample_ready) begin
          check("rx_expected", {31'b0, (exp_q.size() != 0)}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rx_data", {sample_left, sample_right}, e);
            rx_cnt++;
          end
        end
      end
    end
  endtask

  initial begin
    int fe_before;
    fork
      monitor();
    join_none

    repeat (2) @(posedge Clk);
    #1;
    check("reset_left", {16'b0, sample_left}, 32'd0);
    check("reset_right", {16'b0, sample_right}, 32'd0);
    check("reset_valid", {31'b0, sample_valid}, 32'd0);
    check("reset_overrun", {31'b0, overrun}, 32'd0);
    check("reset_frame_err", {31'b0, frame_err}, 32'd0);
    Reset_n      = 1'b1;
    enable       = 1'b1;
    sample_ready = 1'b1;
    repeat (8) @(posedge Clk);
    #1;

    // Basic frame with latency check on the committing edge
    push(16'hA5C3, 16'h1234);
    frame(24'hA5C3, 24'h1234, 16);
    flush(1, 16'h0, 16'h0);
    check("basic_rx_count", rx_cnt, 32'd1);
    check("basic_frame_err", fe_cnt, 32'd0);
    check("basic_overrun", {31'b0, overrun}, 32'd0);

    // 24-bit words truncated to the top 16 bits
    push(16'hABCD, 16'h1234);
    frame(24'hABCDEF, 24'h123456, 24);
    flush(0, 16'h0, 16'h0);
    check("wide_rx_count", rx_cnt, 32'd2);
    check("wide_frame_err", fe_cnt, 32'd0);

    // Consumer stalled across three frames
    sample_ready = 1'b0;
    push(16'h1111, 16'h2222);
    frame(24'h1111, 24'h2222, 16);
    frame(24'h3333, 24'h4444, 16);
    check("stall_f1_valid", {31'b0, sample_valid}, 32'd1);
    check("stall_f1_overrun", {31'b0, overrun}, 32'd0);
    frame(24'h5555, 24'h6666, 16);
    check("stall_f2_overrun", {31'b0, overrun}, 32'd1);
    flush(0, 16'h0, 16'h0);
    check("stall_f3_overrun", {31'b0, overrun}, 32'd1);
    check("stall_keeps_f1", {sample_left, sample_right}, 32'h1111_2222);
    clear_overrun = 1'b1;
    @(posedge Clk);
    #1;
    clear_overrun = 1'b0;
    check("clear_overrun", {31'b0, overrun}, 32'd0);
    sample_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("stall_drained_valid", {31'b0, sample_valid}, 32'd0);
    check("stall_rx_count", rx_cnt, 32'd3);

    // Ready only in the commit cycle while the buffer is full
    sample_ready = 1'b0;
    push(16'h7777, 16'h8888);
    push(16'h9999, 16'hAAAA);
    frame(24'h7777, 24'h8888, 16);
    frame(24'h9999, 24'hAAAA, 16);
    flush(2, 16'h9999, 16'hAAAA);
    check("commit_ready_rx_count", rx_cnt, 32'd4);
    sample_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("commit_ready_drained", {31'b0, sample_valid}, 32'd0);
    check("commit_ready_rx_count2", rx_cnt, 32'd5);

    // Word select toggles after only 8 left bits
    fe_before = fe_cnt;
    half(1'b0, 24'hFFFF, 16, 9);
    half(1'b1, 24'h0, 0, 32);
    check("early_ws_frame_err", fe_cnt, fe_before + 1);
    check("early_ws_no_output", rx_cnt, 32'd5);
    push(16'hBEEF, 16'hCAFE);
    frame(24'hBEEF, 24'hCAFE, 16);
    flush(0, 16'h0, 16'h0);
    check("early_ws_recovery", rx_cnt, 32'd6);
    check("early_ws_single_pulse", fe_cnt, fe_before + 1);

    // Reset in the middle of the right word
    sample_ready = 1'b0;
    frame(24'h0123, 24'h4567, 16);
    half(1'b0, 24'h89AB, 16, 32);
    half(1'b1, 24'hCDEF, 16, 10);
    check("pre_reset_valid", {31'b0, sample_valid}, 32'd1);
    Reset_n = 1'b0;
    #1;
    check("midreset_valid", {31'b0, sample_valid}, 32'd0);
    check("midreset_data", {sample_left, sample_right}, 32'd0);
    check("midreset_overrun", {31'b0, overrun}, 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    Reset_n      = 1'b1;
    sample_ready = 1'b1;
    half(1'b1, 24'h0, 0, 22);
    push(16'hFACE, 16'hB00C);
    frame(24'hFACE, 24'hB00C, 16);
    flush(0, 16'h0, 16'h0);
    check("post_reset_rx_count", rx_cnt, 32'd7);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("total_frame_err", fe_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
